mem_port_scheduler: RTL

- Sequences the single data-memory port between the two execute-to-memory lanes of the dual-issue pipeline. Lane 0 is the older instruction.
- Serialises the lanes' load/store requests in program order and stalls the front of the pipeline until both complete.
- Returns load data per lane.
- Sits between the two execute pipe registers and the data memory.

---
 rtl/mem_port_scheduler_if.sv | 24 ++
 rtl/mem_port_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler_if.sv
// Single data-memory port shared by both execute lanes.
// The scheduler drives the request side; the memory answers with ready/rvalid/rdata.
interface mem_port_scheduler_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ready;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_scheduler.sv
// Serialises the two lanes' load/store requests onto one memory port in program
// order (lane 0 first), stalling the front of the pipeline until both are done.
module mem_port_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int STALL_CNT_BITS = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      lane0_memRead,
  input  logic                      lane0_memWrite,
  input  logic [ADDRESS_BITS-1:0]   lane0_address,
  input  logic [DATA_WIDTH-1:0]     lane0_store_data,
  input  logic                      lane1_memRead,
  input  logic                      lane1_memWrite,
  input  logic [ADDRESS_BITS-1:0]   lane1_address,
  input  logic [DATA_WIDTH-1:0]     lane1_store_data,
  mem_port_scheduler_if.master      mem,
  output logic                      stall,
  output logic [DATA_WIDTH-1:0]     load_data0,
  output logic [DATA_WIDTH-1:0]     load_data1,
  output logic [1:0]                load_valid,
  output logic [STALL_CNT_BITS-1:0] stall_cycles
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

  localparam logic [STALL_CNT_BITS-1:0] CNT_ONE = STALL_CNT_BITS'(1);

  state_t                    state_q, state_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDRESS_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]     load_data0_q, load_data0_d;
  logic [DATA_WIDTH-1:0]     load_data1_q, load_data1_d;
  logic [1:0]                loaded_q, loaded_d;
  logic [1:0]                load_valid_q, load_valid_d;
  logic [STALL_CNT_BITS-1:0] stall_cycles_q, stall_cycles_d;

  logic need0, need1;

  assign need0 = lane0_memRead | lane0_memWrite;
  assign need1 = lane1_memRead | lane1_memWrite;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    load_data0_d = load_data0_q;
    load_data1_d = load_data1_q;
    loaded_d     = loaded_q;
    load_valid_d = 2'b00;

    case (state_q)
      IDLE: begin
        loaded_d = 2'b00;
        if (need0)      state_d = REQ0;
        else if (need1) state_d = REQ1;
      end
      REQ0: begin
        if (mem.mem_ready) begin
          if (mem_we_q) state_d = need1 ? REQ1 : DONE;
          else          state_d = WAIT0;
        end
      end
      WAIT0: begin
        if (mem.mem_rvalid) begin
          load_data0_d = mem.mem_rdata;
          loaded_d[0]  = 1'b1;
          state_d      = need1 ? REQ1 : DONE;
        end
      end
      REQ1: begin
        if (mem.mem_ready) state_d = mem_we_q ? DONE : WAIT1;
      end
      WAIT1: begin
        if (mem.mem_rvalid) begin
          load_data1_d = mem.mem_rdata;
          loaded_d[1]  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request fields latch from the lane on entry to a REQ state and stay put until accepted.
    if (state_d == REQ0) begin
      mem_req_d = 1'b1;
      if (state_q != REQ0) begin
        mem_we_d    = lane0_memWrite;
        mem_addr_d  = lane0_address;
        mem_wdata_d = lane0_store_data;
      end
    end
    if (state_d == REQ1) begin
      mem_req_d = 1'b1;
      if (state_q != REQ1) begin
        mem_we_d    = lane1_memWrite;
        mem_addr_d  = lane1_address;
        mem_wdata_d = lane1_store_data;
      end
    end
    if (state_d == DONE) load_valid_d = loaded_d;
  end

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:                     stall = need0 | need1;
        REQ0, WAIT0, REQ1, WAIT1: stall = 1'b1;
        default:                  stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      load_data0_q   <= '0;
      load_data1_q   <= '0;
      loaded_q       <= 2'b00;
      load_valid_q   <= 2'b00;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      load_data0_q   <= load_data0_d;
      load_data1_q   <= load_data1_d;
      loaded_q       <= loaded_d;
      load_valid_q   <= load_valid_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign load_data0    = load_data0_q;
  assign load_data1    = load_data1_q;
  assign load_valid    = load_valid_q;
  assign stall_cycles  = stall_cycles_q;

endmodule
